// File: rtl/sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_rom_arbiter
//
// Shares one synchronous sprite ROM among NUM_REQ per-pixel requesters
// (tanks, bullets, background, ...) inside the single vga_clk domain.
// Every cycle one requester is granted using round-robin priority and its
// address is driven to the ROM. A valid pipeline that matches the ROM
// latency tags the returned palette index with the owning requester.
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   ADDR_W       ROM address width
//   DATA_W       ROM word width (palette index)
//   ROM_LATENCY  cycles from address sampled to rom_q valid (1..3)
//
// Ports
//   vga_clk      in   pixel clock, the only clock
//   Reset        in   synchronous, active-high reset
//   req          in   per-requester read request (level)
//   req_addr     in   requester i address at [i*ADDR_W +: ADDR_W]
//   gnt          out  one-hot grant, same cycle as the winning req
//   rom_address  out  ROM address port
//   rom_q        in   ROM data port
//   rd_valid     out  one-hot owner of rd_data
//   rd_data      out  returned palette index, 0 when rd_valid is 0
//   busy         out  any read in flight
// ---------------------------------------------------------------------------
module sprite_rom_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 4,
    parameter int ROM_LATENCY = 1
) (
    input  logic                      vga_clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Round-robin pointer: index scanned first, i.e. highest priority.
    logic [PTR_W-1:0]   rr_ptr;
    // Address of the most recent grant; keeps the ROM input stable when idle.
    logic [ADDR_W-1:0]  last_addr;
    // Grant history aligned with the ROM pipeline.
    logic [NUM_REQ-1:0] vpipe [ROM_LATENCY];

    logic               grant_valid;
    logic [PTR_W-1:0]   win;
    logic [PTR_W-1:0]   next_ptr;

    // -----------------------------------------------------------------------
    // Combinational round-robin arbitration
    // -----------------------------------------------------------------------
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        win         = '0;
        idx         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                win         = PTR_W'(idx);
            end
        end
        // Nothing is granted while the block is held in reset.
        if (Reset) begin
            grant_valid = 1'b0;
        end
    end

    always_comb begin
        gnt         = '0;
        rom_address = last_addr;
        if (grant_valid) begin
            gnt         = NUM_REQ'(1) << win;
            rom_address = req_addr[int'(win)*ADDR_W +: ADDR_W];
        end
    end

    // Explicit wrap keeps the pointer inside 0..NUM_REQ-1 even when
    // NUM_REQ is not a power of two.
    always_comb begin
        if (win == PTR_W'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = win + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // State: pointer, held address and valid pipeline
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and the pipeline shifts by exactly one stage.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            rr_ptr    <= '0;
            last_addr <= '0;
            // NOTE: the valid pipeline is a small register array that must be
            // cleared so in-flight reads are dropped; it is not a RAM.
            for (int k = 0; k < ROM_LATENCY; k++) begin
                vpipe[k] <= '0;
            end
        end else begin
            vpipe[0] <= gnt;
            for (int k = 1; k < ROM_LATENCY; k++) begin
                vpipe[k] <= vpipe[k-1];
            end
            if (grant_valid) begin
                last_addr <= rom_address;
                rr_ptr    <= next_ptr;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read return path
    // -----------------------------------------------------------------------
    assign rd_valid = vpipe[ROM_LATENCY-1];
    assign rd_data  = (rd_valid != '0) ? rom_q : '0;

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < ROM_LATENCY; k++) begin
            busy = busy | (|vpipe[k]);
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sprite_rom_arbiter
//
// Directed bench for sprite_rom_arbiter. Two instances share the stimulus:
// dut_a with ROM_LATENCY=1 and dut_b with ROM_LATENCY=3, each with its own
// behavioural ROM whose contents are rom_fn(addr) = ~addr[3:0].
// Inputs change at the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_sprite_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [39:0] req_addr;

    logic [3:0]  gnt_a, valid_a, q_a, data_a;
    logic [9:0]  addr_a;
    logic        busy_a;
    logic [3:0]  gnt_b, valid_b, q_b, data_b;
    logic [9:0]  addr_b;
    logic        busy_b;
    logic [3:0]  p0_b, p1_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] rom_fn(input logic [9:0] a);
        return ~a[3:0];
    endfunction

    // Behavioural synchronous ROMs of latency 1 and 3.
    always @(posedge clk) begin
        q_a  <= rom_fn(addr_a);
        p0_b <= rom_fn(addr_b);
        p1_b <= p0_b;
        q_b  <= p1_b;
    end

    sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(4), .ROM_LATENCY(1)) dut_a (
        .vga_clk(clk), .Reset(rst), .req(req), .req_addr(req_addr), .gnt(gnt_a),
        .rom_address(addr_a), .rom_q(q_a), .rd_valid(valid_a), .rd_data(data_a), .busy(busy_a)
    );

    sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(10), .DATA_W(4), .ROM_LATENCY(3)) dut_b (
        .vga_clk(clk), .Reset(rst), .req(req), .req_addr(req_addr), .gnt(gnt_b),
        .rom_address(addr_b), .rom_q(q_b), .rd_valid(valid_b), .rd_data(data_b), .busy(busy_b)
    );

    task automatic cyc(input logic r, input logic [3:0] rq);
        @(negedge clk);
        rst = r;
        req = rq;
        #1;
    endtask

    task automatic set_addr(input int i, input logic [9:0] a);
        req_addr[i*10 +: 10] = a;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        cyc(1'b1, 4'b1111);
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, 4'b1111);
            total_cnt++; if (gnt_a !== 4'b0000) $display("FAIL reset_gnt_a c%0d got %b want 0000", c, gnt_a); else pass_cnt++;
            total_cnt++; if (gnt_b !== 4'b0000) $display("FAIL reset_gnt_b c%0d got %b want 0000", c, gnt_b); else pass_cnt++;
            total_cnt++; if (valid_a !== 4'b0000) $display("FAIL reset_valid_a c%0d got %b want 0000", c, valid_a); else pass_cnt++;
            total_cnt++; if (valid_b !== 4'b0000) $display("FAIL reset_valid_b c%0d got %b want 0000", c, valid_b); else pass_cnt++;
            total_cnt++; if (addr_a !== 10'd0) $display("FAIL reset_addr_a c%0d got %0d want 0", c, addr_a); else pass_cnt++;
            total_cnt++; if (addr_b !== 10'd0) $display("FAIL reset_addr_b c%0d got %0d want 0", c, addr_b); else pass_cnt++;
            total_cnt++; if (data_a !== 4'h0) $display("FAIL reset_data_a c%0d got %h want 0", c, data_a); else pass_cnt++;
            total_cnt++; if (busy_b !== 1'b0) $display("FAIL reset_busy_b c%0d got %b want 0", c, busy_b); else pass_cnt++;
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_single();
        set_addr(0, 10'd5); set_addr(1, 10'd6); set_addr(2, 10'd37); set_addr(3, 10'd8);
        cyc(1'b0, 4'b0100);   // cycle t
        total_cnt++; if (gnt_a !== 4'b0100) $display("FAIL single_gnt_a got %b want 0100", gnt_a); else pass_cnt++;
        total_cnt++; if (gnt_b !== 4'b0100) $display("FAIL single_gnt_b got %b want 0100", gnt_b); else pass_cnt++;
        total_cnt++; if (addr_a !== 10'd37) $display("FAIL single_addr_t got %0d want 37", addr_a); else pass_cnt++;
        cyc(1'b0, 4'b0000);   // t+1
        total_cnt++; if (valid_a !== 4'b0100) $display("FAIL single_valid_a got %b want 0100", valid_a); else pass_cnt++;
        total_cnt++; if (data_a !== 4'hA) $display("FAIL single_data_a got %h want a", data_a); else pass_cnt++;
        total_cnt++; if (addr_a !== 10'd37) $display("FAIL single_addr_hold got %0d want 37", addr_a); else pass_cnt++;
        total_cnt++; if (gnt_a !== 4'b0000) $display("FAIL single_idle_gnt got %b want 0000", gnt_a); else pass_cnt++;
        total_cnt++; if (valid_b !== 4'b0000) $display("FAIL single_valid_b_t1 got %b want 0000", valid_b); else pass_cnt++;
        total_cnt++; if (busy_b !== 1'b1) $display("FAIL single_busy_b_t1 got %b want 1", busy_b); else pass_cnt++;
        cyc(1'b0, 4'b0000);   // t+2
        total_cnt++; if (valid_a !== 4'b0000) $display("FAIL single_valid_a_t2 got %b want 0000", valid_a); else pass_cnt++;
        total_cnt++; if (data_a !== 4'h0) $display("FAIL single_data_a_t2 got %h want 0", data_a); else pass_cnt++;
        total_cnt++; if (busy_a !== 1'b0) $display("FAIL single_busy_a_t2 got %b want 0", busy_a); else pass_cnt++;
        cyc(1'b0, 4'b0000);   // t+3
        total_cnt++; if (valid_b !== 4'b0100) $display("FAIL single_valid_b_t3 got %b want 0100", valid_b); else pass_cnt++;
        total_cnt++; if (data_b !== 4'hA) $display("FAIL single_data_b_t3 got %h want a", data_b); else pass_cnt++;
        cyc(1'b0, 4'b0000);   // t+4
        total_cnt++; if (busy_b !== 1'b0) $display("FAIL single_busy_b_t4 got %b want 0", busy_b); else pass_cnt++;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_round_robin();
        logic [3:0] exp_g [4];
        logic [3:0] exp_d [4];
        logic [9:0] adr   [4];
        adr[0] = 10'h010; adr[1] = 10'h021; adr[2] = 10'h032; adr[3] = 10'h043;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000;
        exp_d[0] = 4'hF; exp_d[1] = 4'hE; exp_d[2] = 4'hD; exp_d[3] = 4'hC;
        for (int i = 0; i < 4; i++) set_addr(i, adr[i]);
        cyc(1'b1, 4'b0000);
        for (int k = 0; k < 9; k++) begin
            cyc(1'b0, (k < 8) ? 4'b1111 : 4'b0000);
            if (k < 8) begin
                total_cnt++; if (gnt_a !== exp_g[k%4]) $display("FAIL rr_gnt_a k%0d got %b want %b", k, gnt_a, exp_g[k%4]); else pass_cnt++;
                total_cnt++; if (gnt_b !== exp_g[k%4]) $display("FAIL rr_gnt_b k%0d got %b want %b", k, gnt_b, exp_g[k%4]); else pass_cnt++;
                total_cnt++; if (addr_a !== adr[k%4]) $display("FAIL rr_addr k%0d got %h want %h", k, addr_a, adr[k%4]); else pass_cnt++;
            end
            if (k > 0) begin
                total_cnt++; if (valid_a !== exp_g[(k-1)%4]) $display("FAIL rr_valid k%0d got %b want %b", k, valid_a, exp_g[(k-1)%4]); else pass_cnt++;
                total_cnt++; if (data_a !== exp_d[(k-1)%4]) $display("FAIL rr_data k%0d got %h want %h", k, data_a, exp_d[(k-1)%4]); else pass_cnt++;
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_skip_wrap();
        logic [3:0] exp_g [3];
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0001;
        cyc(1'b0, 4'b0100);   // pointer 0 -> grant 2 -> pointer 3
        total_cnt++; if (gnt_a !== 4'b0100) $display("FAIL skip_setup got %b want 0100", gnt_a); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 4'b0011);
            total_cnt++; if (gnt_a !== exp_g[k]) $display("FAIL skip_gnt_a k%0d got %b want %b", k, gnt_a, exp_g[k]); else pass_cnt++;
            total_cnt++; if (gnt_b !== exp_g[k]) $display("FAIL skip_gnt_b k%0d got %b want %b", k, gnt_b, exp_g[k]); else pass_cnt++;
        end
        cyc(1'b0, 4'b0000);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_latency();
        logic [3:0] exp_v [4];
        exp_v[0] = 4'b0000; exp_v[1] = 4'b0000; exp_v[2] = 4'b0010; exp_v[3] = 4'b0000;
        repeat (3) cyc(1'b0, 4'b0000);
        set_addr(1, 10'd100);
        cyc(1'b0, 4'b0010);   // cycle t
        total_cnt++; if (gnt_b !== 4'b0010) $display("FAIL lat_gnt got %b want 0010", gnt_b); else pass_cnt++;
        total_cnt++; if (busy_b !== 1'b0) $display("FAIL lat_busy_t got %b want 0", busy_b); else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 4'b0000);   // t+1 .. t+4
            total_cnt++; if (valid_b !== exp_v[k]) $display("FAIL lat_valid t+%0d got %b want %b", k+1, valid_b, exp_v[k]); else pass_cnt++;
            total_cnt++; if (busy_b !== (k < 3)) $display("FAIL lat_busy t+%0d got %b want %b", k+1, busy_b, (k < 3)); else pass_cnt++;
            if (k == 2) begin
                total_cnt++; if (data_b !== 4'hB) $display("FAIL lat_data got %h want b", data_b); else pass_cnt++;
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_midflight();
        // Pointer is 2 here; scan 2,3,0 picks requester 0.
        cyc(1'b0, 4'b0001);   // t: grant
        total_cnt++; if (gnt_b !== 4'b0001) $display("FAIL mid_gnt_t got %b want 0001", gnt_b); else pass_cnt++;
        cyc(1'b1, 4'b0000);   // t+1: Reset sampled at the end of this cycle
        total_cnt++; if (busy_b !== 1'b1) $display("FAIL mid_busy_t1 got %b want 1", busy_b); else pass_cnt++;
        cyc(1'b1, 4'b1010);   // t+2
        total_cnt++; if (gnt_b !== 4'b0000) $display("FAIL mid_gnt_in_reset got %b want 0000", gnt_b); else pass_cnt++;
        total_cnt++; if (valid_b !== 4'b0000) $display("FAIL mid_valid_t2 got %b want 0000", valid_b); else pass_cnt++;
        total_cnt++; if (busy_b !== 1'b0) $display("FAIL mid_busy_t2 got %b want 0", busy_b); else pass_cnt++;
        cyc(1'b0, 4'b1010);   // t+3: grant would have returned here
        total_cnt++; if (valid_b !== 4'b0000) $display("FAIL mid_valid_t3 got %b want 0000", valid_b); else pass_cnt++;
        total_cnt++; if (gnt_a !== 4'b0010) $display("FAIL mid_first_gnt_a got %b want 0010", gnt_a); else pass_cnt++;
        total_cnt++; if (gnt_b !== 4'b0010) $display("FAIL mid_first_gnt_b got %b want 0010", gnt_b); else pass_cnt++;

        // Latency-1 case: grant seen, then Reset raised before the edge.
        cyc(1'b0, 4'b0100);
        total_cnt++; if (gnt_a !== 4'b0100) $display("FAIL mid1_gnt got %b want 0100", gnt_a); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (gnt_a !== 4'b0000) $display("FAIL mid1_gnt_gated got %b want 0000", gnt_a); else pass_cnt++;
        cyc(1'b1, 4'b0000);
        total_cnt++; if (valid_a !== 4'b0000) $display("FAIL mid1_valid got %b want 0000", valid_a); else pass_cnt++;
        total_cnt++; if (data_a !== 4'h0) $display("FAIL mid1_data got %h want 0", data_a); else pass_cnt++;
        total_cnt++; if (addr_a !== 10'd0) $display("FAIL mid1_addr got %0d want 0", addr_a); else pass_cnt++;
        cyc(1'b0, 4'b1010);
        total_cnt++; if (gnt_a !== 4'b0010) $display("FAIL mid1_first_gnt got %b want 0010", gnt_a); else pass_cnt++;
    endtask

    // -----------------------------------------------------------------------
    initial begin
        rst      = 1'b1;
        req      = 4'b0000;
        req_addr = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_skip_wrap();
        test_latency();
        test_reset_midflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
